tx_rd_req_sched: RTL and testbench

Scheduler for the TX DMA host-read request path. It shares the single read-request TLP generator between two requesters:
- the fresh-chunk requester (TX DMA engine);
- the timeout-retry requester (retry monitor).

It arbitrates with bounded retry priority, limits outstanding fresh reads, and tracks busy tags so that no tag is reissued fresh before its completion is fully retired.

---
 rtl/tx_rd_req_pkg.sv | 32 +++
 rtl/tx_rd_req_sched_if.sv | 56 +++++
 rtl/tx_rd_tag_tracker.sv | 72 +++++++
 rtl/tx_rd_req_sched.sv | 199 +++++++++++++++++++
 tb/tb_tx_rd_req_sched.sv | 329 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/tx_rd_req_pkg.sv
// rtl/tx_rd_req_pkg.sv - shared types and constants for the TX read-request scheduler
//
// Purpose: FSM state encoding, grant-source encoding, field widths and the
//          qword-to-dword length conversion used by the scheduler slice.
// Ports:   none (package).
package tx_rd_req_pkg;

  localparam int TAG_W    = 4;
  localparam int LEN_DW_W = 10;
  localparam int LEN_QW_W = 9;
  localparam int ADDR_W   = 64;
  localparam int NUM_TAGS = 1 << TAG_W;
  localparam int CNT_W    = 5;
  localparam int STREAK_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_ACK = 2'd1,
    ST_GAP      = 2'd2
  } sched_state_t;

  typedef enum logic {
    GNT_FRESH = 1'b0,
    GNT_RETRY = 1'b1
  } gnt_src_t;

  // Fresh requests are sized in qwords; the TLP generator wants dwords.
  function automatic logic [LEN_DW_W-1:0] qw_to_dw(input logic [LEN_QW_W-1:0] qw);
    return {qw, 1'b0};
  endfunction

endpackage

// File: rtl/tx_rd_req_sched_if.sv
// rtl/tx_rd_req_sched_if.sv - handshake bundle between requesters, scheduler and TLP generator
//
// Purpose: groups the fresh-request, retry-request, TLP-generator and
//          tag-release signals of the scheduler.
// Modports:
//   slave  - scheduler view (consumes requests, drives grants/acks/status)
//   master - environment view (requesters, TLP generator, completion retire)
interface tx_rd_req_sched_if;
  import tx_rd_req_pkg::*;

  logic                req_valid;
  logic [ADDR_W-1:0]   req_addr;
  logic [TAG_W-1:0]    req_tag;
  logic [LEN_QW_W-1:0] req_qwords;
  logic                req_ack;

  logic                retry_valid;
  logic [ADDR_W-1:0]   retry_addr;
  logic [TAG_W-1:0]    retry_tag;
  logic [LEN_DW_W-1:0] retry_dwords;
  logic                retry_ack;

  logic                rd_req;
  logic [ADDR_W-1:0]   rd_addr;
  logic [TAG_W-1:0]    rd_tag;
  logic [LEN_DW_W-1:0] rd_dwords;
  logic                rd_ack;

  logic                tag_release;
  logic [TAG_W-1:0]    tag_release_id;
  logic [NUM_TAGS-1:0] tag_busy;
  logic [CNT_W-1:0]    outstanding_cnt;

  modport slave (
    input  req_valid, req_addr, req_tag, req_qwords,
    output req_ack,
    input  retry_valid, retry_addr, retry_tag, retry_dwords,
    output retry_ack,
    output rd_req, rd_addr, rd_tag, rd_dwords,
    input  rd_ack,
    input  tag_release, tag_release_id,
    output tag_busy, outstanding_cnt
  );

  modport master (
    output req_valid, req_addr, req_tag, req_qwords,
    input  req_ack,
    output retry_valid, retry_addr, retry_tag, retry_dwords,
    input  retry_ack,
    input  rd_req, rd_addr, rd_tag, rd_dwords,
    output rd_ack,
    output tag_release, tag_release_id,
    input  tag_busy, outstanding_cnt
  );

endinterface

// File: rtl/tx_rd_tag_tracker.sv
// rtl/tx_rd_tag_tracker.sv - busy-tag bitmap and outstanding fresh-read counter
//
// Purpose: records which tags have a fresh read in flight, counts them, merges
//          same-cycle issue and release, and reports whether a fresh request
//          for query_tag could be granted now.
// Ports:
//   trn_clk, reset_n      clock, synchronous active-low reset
//   issue, issue_tag      fresh read accepted by the TLP generator this cycle
//   rel_vld, rel_id       completion for rel_id fully retired
//   query_tag             tag of the pending fresh request
//   tag_busy              per-tag in-flight bitmap
//   outstanding_cnt       fresh reads in flight
//   fresh_room            slot available and query_tag not busy
module tx_rd_tag_tracker
  import tx_rd_req_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                trn_clk,
  input  logic                reset_n,
  input  logic                issue,
  input  logic [TAG_W-1:0]    issue_tag,
  input  logic                rel_vld,
  input  logic [TAG_W-1:0]    rel_id,
  input  logic [TAG_W-1:0]    query_tag,
  output logic [NUM_TAGS-1:0] tag_busy,
  output logic [CNT_W-1:0]    outstanding_cnt,
  output logic                fresh_room
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUTSTANDING);

  logic [NUM_TAGS-1:0] busy_q, busy_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                rel_hit;

  // A release counts when the tag is in flight, or when it names the tag being
  // issued in this very cycle: the two cancel in the count while the bitmap
  // keeps the tag marked busy (the set is applied after the clear).
  assign rel_hit = rel_vld && (busy_q[rel_id] || (issue && (issue_tag == rel_id)));

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    if (rel_hit) begin
      busy_d[rel_id] = 1'b0;
    end
    if (issue) begin
      busy_d[issue_tag] = 1'b1;
    end
    case ({issue, rel_hit})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge trn_clk) begin
    if (!reset_n) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

  assign tag_busy        = busy_q;
  assign outstanding_cnt = cnt_q;
  assign fresh_room      = (cnt_q < MAX_CNT) && !busy_q[query_tag];

endmodule

// File: rtl/tx_rd_req_sched.sv
// rtl/tx_rd_req_sched.sv - arbiter between fresh-chunk and timeout-retry host read requests
//
// Purpose: shares one read-request TLP generator between the TX DMA fresh
//          requester and the retry monitor. Retry has priority for at most
//          RETRY_BURST_MAX consecutive grants while a fresh request is
//          eligible; fresh reads are limited to MAX_OUTSTANDING in flight and
//          a tag is never reissued fresh until its completion is retired.
// Ports:
//   trn_clk, reset_n   clock, synchronous active-low reset
//   bus (slave)        fresh/retry requests and acks, TLP-generator request,
//                      tag release, tag_busy and outstanding_cnt status
//   stat_*             grant/stall statistics (only with TX_RD_REQ_STATS_EN)
// Optional feature macro: TX_RD_REQ_STATS_EN
module tx_rd_req_sched
  import tx_rd_req_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 4,
  parameter int RETRY_BURST_MAX = 4
) (
  input  logic               trn_clk,
  input  logic               reset_n,
  tx_rd_req_sched_if.slave   bus
`ifdef TX_RD_REQ_STATS_EN
  ,
  output logic [31:0]        stat_fresh_grants,
  output logic [31:0]        stat_retry_grants,
  output logic [31:0]        stat_stall_cycles
`endif
);

  localparam logic [STREAK_W-1:0] BURST_MAX = STREAK_W'(RETRY_BURST_MAX);

  sched_state_t        state_q, state_d;
  gnt_src_t            src_q, src_d;
  logic                rd_req_q, rd_req_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic [LEN_DW_W-1:0] dw_q, dw_d;
  logic                req_ack_q, req_ack_d;
  logic                retry_ack_q, retry_ack_d;
  logic [STREAK_W-1:0] streak_q, streak_d;
  logic                elig_at_gnt_q, elig_at_gnt_d;

  logic                fresh_room;
  logic                fresh_elig;
  logic                grant_retry;
  logic                grant_fresh;
  logic                issue_fresh;

  tx_rd_tag_tracker #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) u_tag_tracker (
    .trn_clk         (trn_clk),
    .reset_n         (reset_n),
    .issue           (issue_fresh),
    .issue_tag       (tag_q),
    .rel_vld         (bus.tag_release),
    .rel_id          (bus.tag_release_id),
    .query_tag       (bus.req_tag),
    .tag_busy        (bus.tag_busy),
    .outstanding_cnt (bus.outstanding_cnt),
    .fresh_room      (fresh_room)
  );

  assign fresh_elig  = bus.req_valid && fresh_room;
  // Retry yields to an eligible fresh request only once its streak is used up.
  assign grant_retry = (state_q == ST_IDLE) && bus.retry_valid &&
                       (!fresh_elig || (streak_q < BURST_MAX));
  assign grant_fresh = (state_q == ST_IDLE) && !grant_retry && fresh_elig;

  always_comb begin
    state_d       = state_q;
    src_d         = src_q;
    rd_req_d      = rd_req_q;
    addr_d        = addr_q;
    tag_d         = tag_q;
    dw_d          = dw_q;
    req_ack_d     = 1'b0;
    retry_ack_d   = 1'b0;
    streak_d      = streak_q;
    elig_at_gnt_d = elig_at_gnt_q;
    issue_fresh   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (grant_retry) begin
          src_d         = GNT_RETRY;
          addr_d        = bus.retry_addr;
          tag_d         = bus.retry_tag;
          dw_d          = bus.retry_dwords;
          elig_at_gnt_d = fresh_elig;
          rd_req_d      = 1'b1;
          state_d       = ST_WAIT_ACK;
        end else if (grant_fresh) begin
          src_d         = GNT_FRESH;
          addr_d        = bus.req_addr;
          tag_d         = bus.req_tag;
          dw_d          = qw_to_dw(bus.req_qwords);
          elig_at_gnt_d = 1'b1;
          if (bus.req_qwords == '0) begin
            // Nothing to fetch: acknowledge without touching the generator
            // or allocating the tag.
            req_ack_d = 1'b1;
            streak_d  = '0;
            state_d   = ST_GAP;
          end else begin
            rd_req_d = 1'b1;
            state_d  = ST_WAIT_ACK;
          end
        end
      end

      ST_WAIT_ACK: begin
        if (bus.rd_ack) begin
          rd_req_d = 1'b0;
          state_d  = ST_GAP;
          if (src_q == GNT_FRESH) begin
            req_ack_d   = 1'b1;
            issue_fresh = 1'b1;
            streak_d    = '0;
          end else begin
            retry_ack_d = 1'b1;
            // Only retries that actually held off a waiting fresh request
            // count toward the burst limit.
            if (elig_at_gnt_q) begin
              streak_d = (streak_q < BURST_MAX) ? streak_q + STREAK_W'(1) : streak_q;
            end else begin
              streak_d = '0;
            end
          end
        end
      end

      // Gives the acknowledged requester a cycle to drop its valid.
      ST_GAP: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d  = ST_IDLE;
        rd_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge trn_clk) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      src_q         <= GNT_FRESH;
      rd_req_q      <= 1'b0;
      addr_q        <= '0;
      tag_q         <= '0;
      dw_q          <= '0;
      req_ack_q     <= 1'b0;
      retry_ack_q   <= 1'b0;
      streak_q      <= '0;
      elig_at_gnt_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      src_q         <= src_d;
      rd_req_q      <= rd_req_d;
      addr_q        <= addr_d;
      tag_q         <= tag_d;
      dw_q          <= dw_d;
      req_ack_q     <= req_ack_d;
      retry_ack_q   <= retry_ack_d;
      streak_q      <= streak_d;
      elig_at_gnt_q <= elig_at_gnt_d;
    end
  end

  assign bus.rd_req    = rd_req_q;
  assign bus.rd_addr   = addr_q;
  assign bus.rd_tag    = tag_q;
  assign bus.rd_dwords = dw_q;
  assign bus.req_ack   = req_ack_q;
  assign bus.retry_ack = retry_ack_q;

`ifdef TX_RD_REQ_STATS_EN
  always_ff @(posedge trn_clk) begin
    if (!reset_n) begin
      stat_fresh_grants <= '0;
      stat_retry_grants <= '0;
      stat_stall_cycles <= '0;
    end else begin
      if (grant_fresh) begin
        stat_fresh_grants <= stat_fresh_grants + 32'd1;
      end
      if (grant_retry) begin
        stat_retry_grants <= stat_retry_grants + 32'd1;
      end
      if (bus.req_valid && !fresh_elig) begin
        stat_stall_cycles <= stat_stall_cycles + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_tx_rd_req_sched.sv
// tb/tb_tx_rd_req_sched.sv - self-checking bench for tx_rd_req_sched
module tb_tx_rd_req_sched;
  import tx_rd_req_pkg::*;

  localparam int MAXO  = 4;
  localparam int BURST = 4;

  logic trn_clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 trn_clk = ~trn_clk;

  tx_rd_req_sched_if bus ();

`ifdef TX_RD_REQ_STATS_EN
  logic [31:0] stat_fresh_grants, stat_retry_grants, stat_stall_cycles;
`endif

  tx_rd_req_sched #(.MAX_OUTSTANDING(MAXO), .RETRY_BURST_MAX(BURST)) dut (
    .trn_clk (trn_clk),
    .reset_n (reset_n),
    .bus     (bus)
`ifdef TX_RD_REQ_STATS_EN
    ,
    .stat_fresh_grants (stat_fresh_grants),
    .stat_retry_grants (stat_retry_grants),
    .stat_stall_cycles (stat_stall_cycles)
`endif
  );

  int n_checks = 0;
  int n_fail   = 0;
  int ack_delay = 0;
  int wait_cnt  = 0;
  bit          hs_seen;
  logic [63:0] hs_addr;
  logic [3:0]  hs_tag;
  logic [9:0]  hs_dw;

  // One clock: capture an accepted request, then act as the TLP generator.
  task automatic step();
    if (bus.rd_req && bus.rd_ack) begin
      hs_seen = 1'b1; hs_addr = bus.rd_addr; hs_tag = bus.rd_tag; hs_dw = bus.rd_dwords;
    end
    @(posedge trn_clk); #1;
    bus.tag_release = 1'b0;
    if (bus.rd_ack) begin
      bus.rd_ack = 1'b0; wait_cnt = 0;
    end else if (bus.rd_req) begin
      wait_cnt++;
      if (wait_cnt > ack_delay) bus.rd_ack = 1'b1;
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    bus.req_valid = 0; bus.req_addr = 0; bus.req_tag = 0; bus.req_qwords = 0;
    bus.retry_valid = 0; bus.retry_addr = 0; bus.retry_tag = 0; bus.retry_dwords = 0;
    bus.rd_ack = 0; bus.tag_release = 0; bus.tag_release_id = 0;
    wait_cnt = 0;
    step(); step();
    reset_n = 1'b1;
  endtask

  // Steps until either ack is seen (src 1 fresh, 2 retry) or the budget expires (src 0).
  task automatic wait_grant(input int max_cyc, output int src, output bit saw_req);
    src = 0; saw_req = 0; hs_seen = 0;
    for (int c = 0; c < max_cyc; c++) begin
      step();
      if (bus.rd_req) saw_req = 1;
      if (bus.req_ack) begin src = 1; break; end
      if (bus.retry_ack) begin src = 2; break; end
    end
  endtask

  task automatic set_fresh(input logic [63:0] a, input logic [3:0] t, input logic [8:0] q);
    bus.req_valid = 1; bus.req_addr = a; bus.req_tag = t; bus.req_qwords = q;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (bus.rd_req !== 1'b0 || bus.req_ack !== 1'b0 || bus.retry_ack !== 1'b0) begin
      n_fail++; $display("FAIL reset_ctl: rd_req=%b req_ack=%b retry_ack=%b expected 0", bus.rd_req, bus.req_ack, bus.retry_ack); end
    n_checks++; if (bus.tag_busy !== 16'h0 || bus.outstanding_cnt !== 5'd0) begin
      n_fail++; $display("FAIL reset_state: tag_busy=%h cnt=%0d expected 0", bus.tag_busy, bus.outstanding_cnt); end
    n_checks++; if (bus.rd_addr !== 64'h0 || bus.rd_tag !== 4'h0 || bus.rd_dwords !== 10'h0) begin
      n_fail++; $display("FAIL reset_payload: addr=%h tag=%h dw=%h expected 0", bus.rd_addr, bus.rd_tag, bus.rd_dwords); end
  endtask

  task automatic test_fresh_only();
    int src; bit saw;
    do_reset(); ack_delay = 2;
    set_fresh(64'h1000, 4'd3, 9'd16);
    wait_grant(20, src, saw);
    bus.req_valid = 0;
    n_checks++; if (src !== 1) begin n_fail++; $display("FAIL fresh_src: got %0d expected 1", src); end
    n_checks++; if (hs_dw !== 10'd32 || hs_tag !== 4'd3 || hs_addr !== 64'h1000) begin
      n_fail++; $display("FAIL fresh_payload: dw=%0d tag=%0d addr=%h expected 32 3 1000", hs_dw, hs_tag, hs_addr); end
    n_checks++; if (bus.tag_busy !== 16'h0008 || bus.outstanding_cnt !== 5'd1) begin
      n_fail++; $display("FAIL fresh_track: busy=%h cnt=%0d expected 0008 1", bus.tag_busy, bus.outstanding_cnt); end
    step();
    n_checks++; if (bus.req_ack !== 1'b0 || bus.rd_req !== 1'b0) begin
      n_fail++; $display("FAIL fresh_pulse: req_ack=%b rd_req=%b expected 0 0", bus.req_ack, bus.rd_req); end
  endtask

  task automatic test_retry_burst();
    int src; bit saw;
    int exp_order[10] = '{2, 2, 2, 2, 1, 2, 2, 2, 2, 1};
    logic [63:0] ra; logic [9:0] rdw;
    do_reset(); ack_delay = 0;
    set_fresh(64'hABC0, 4'd7, 9'd4);
    ra = {$urandom, $urandom}; rdw = 10'($urandom_range(1, 1023));
    bus.retry_valid = 1; bus.retry_addr = ra; bus.retry_tag = 4'($urandom_range(0, 15)); bus.retry_dwords = rdw;
    for (int i = 0; i < 10; i++) begin
      wait_grant(20, src, saw);
      n_checks++; if (src !== exp_order[i]) begin
        n_fail++; $display("FAIL burst_order[%0d]: got %0d expected %0d", i, src, exp_order[i]); end
      if (src == 2) begin
        n_checks++; if (hs_addr !== ra || hs_dw !== rdw) begin
          n_fail++; $display("FAIL burst_retry_payload[%0d]: addr=%h dw=%0d expected %h %0d", i, hs_addr, hs_dw, ra, rdw); end
        ra = {$urandom, $urandom}; rdw = 10'($urandom_range(1, 1023));
        bus.retry_addr = ra; bus.retry_dwords = rdw;
      end else if (src == 1) begin
        n_checks++; if (hs_tag !== 4'd7 || hs_dw !== 10'd8) begin
          n_fail++; $display("FAIL burst_fresh_payload[%0d]: tag=%0d dw=%0d expected 7 8", i, hs_tag, hs_dw); end
        bus.tag_release = 1; bus.tag_release_id = 4'd7;
      end
    end
    bus.req_valid = 0; bus.retry_valid = 0; step();
  endtask

  task automatic test_outstanding_limit();
    int src; bit saw;
    do_reset(); ack_delay = 0;
    for (int i = 0; i < 4; i++) begin
      set_fresh(64'h2000 + 64'(i), 4'(i), 9'd1);
      wait_grant(20, src, saw);
      n_checks++; if (src !== 1) begin n_fail++; $display("FAIL limit_fill[%0d]: got %0d expected 1", i, src); end
    end
    n_checks++; if (bus.outstanding_cnt !== 5'd4 || bus.tag_busy !== 16'h000F) begin
      n_fail++; $display("FAIL limit_full: cnt=%0d busy=%h expected 4 000f", bus.outstanding_cnt, bus.tag_busy); end
    set_fresh(64'h2004, 4'd4, 9'd2);
    wait_grant(8, src, saw);
    n_checks++; if (src !== 0 || saw !== 1'b0) begin
      n_fail++; $display("FAIL limit_stall: src=%0d rd_req_seen=%b expected 0 0", src, saw); end
    bus.tag_release = 1; bus.tag_release_id = 4'd1;
    step();
    n_checks++; if (bus.outstanding_cnt !== 5'd3) begin
      n_fail++; $display("FAIL limit_release: cnt=%0d expected 3", bus.outstanding_cnt); end
    wait_grant(10, src, saw);
    bus.req_valid = 0;
    n_checks++; if (src !== 1 || hs_tag !== 4'd4) begin
      n_fail++; $display("FAIL limit_regrant: src=%0d tag=%0d expected 1 4", src, hs_tag); end
    n_checks++; if (bus.outstanding_cnt !== 5'd4 || bus.tag_busy !== 16'h001D) begin
      n_fail++; $display("FAIL limit_after: cnt=%0d busy=%h expected 4 001d", bus.outstanding_cnt, bus.tag_busy); end
    step();
  endtask

  task automatic test_tag_reuse();
    int src; bit saw;
    do_reset(); ack_delay = 1;
    set_fresh(64'h5000, 4'd5, 9'd2);
    wait_grant(20, src, saw);
    bus.req_addr = 64'h5100;
    bus.retry_valid = 1; bus.retry_addr = 64'h9500; bus.retry_tag = 4'd5; bus.retry_dwords = 10'd7;
    wait_grant(20, src, saw);
    bus.retry_valid = 0;
    n_checks++; if (src !== 2 || hs_tag !== 4'd5 || hs_addr !== 64'h9500) begin
      n_fail++; $display("FAIL reuse_retry: src=%0d tag=%0d addr=%h expected 2 5 9500", src, hs_tag, hs_addr); end
    n_checks++; if (bus.tag_busy !== 16'h0020 || bus.outstanding_cnt !== 5'd1) begin
      n_fail++; $display("FAIL reuse_track: busy=%h cnt=%0d expected 0020 1", bus.tag_busy, bus.outstanding_cnt); end
    wait_grant(8, src, saw);
    n_checks++; if (src !== 0) begin n_fail++; $display("FAIL reuse_stall: got %0d expected 0", src); end
    bus.tag_release = 1; bus.tag_release_id = 4'd5;
    wait_grant(10, src, saw);
    bus.req_valid = 0;
    n_checks++; if (src !== 1 || hs_addr !== 64'h5100) begin
      n_fail++; $display("FAIL reuse_fresh: src=%0d addr=%h expected 1 5100", src, hs_addr); end
    n_checks++; if (bus.tag_busy !== 16'h0020 || bus.outstanding_cnt !== 5'd1) begin
      n_fail++; $display("FAIL reuse_after: busy=%h cnt=%0d expected 0020 1", bus.tag_busy, bus.outstanding_cnt); end
    step();
  endtask

  // Issue `t` and release `r` at the edge where the generator accepts `t`.
  task automatic issue_with_release(input logic [3:0] t, input logic [3:0] r, output int src);
    bit saw; int c;
    set_fresh(64'h7000 + 64'(t), t, 9'd3);
    c = 0;
    while (bus.rd_ack !== 1'b1 && c < 12) begin step(); c++; end
    bus.tag_release = 1; bus.tag_release_id = r;
    wait_grant(6, src, saw);
    bus.req_valid = 0;
  endtask

  task automatic test_simul_release();
    int src; bit saw;
    do_reset(); ack_delay = 0;
    set_fresh(64'h6000, 4'd6, 9'd1);
    wait_grant(20, src, saw);
    bus.req_valid = 0; step();
    ack_delay = 1;
    issue_with_release(4'd2, 4'd2, src);
    n_checks++; if (src !== 1 || bus.outstanding_cnt !== 5'd1 || bus.tag_busy !== 16'h0044) begin
      n_fail++; $display("FAIL simul_same: src=%0d cnt=%0d busy=%h expected 1 1 0044", src, bus.outstanding_cnt, bus.tag_busy); end
    step();
    bus.tag_release = 1; bus.tag_release_id = 4'd9;
    step();
    n_checks++; if (bus.outstanding_cnt !== 5'd1 || bus.tag_busy !== 16'h0044) begin
      n_fail++; $display("FAIL simul_idle_rel: cnt=%0d busy=%h expected 1 0044", bus.outstanding_cnt, bus.tag_busy); end
    issue_with_release(4'd1, 4'd6, src);
    n_checks++; if (src !== 1 || bus.outstanding_cnt !== 5'd1 || bus.tag_busy !== 16'h0006) begin
      n_fail++; $display("FAIL simul_diff: src=%0d cnt=%0d busy=%h expected 1 1 0006", src, bus.outstanding_cnt, bus.tag_busy); end
    step();
  endtask

  task automatic test_reset_mid();
    int src; bit saw; int c;
    do_reset(); ack_delay = 0;
    set_fresh(64'h1100, 4'd1, 9'd1);
    wait_grant(20, src, saw);
    bus.req_valid = 0; step();
    ack_delay = 50;
    set_fresh(64'h1800, 4'd8, 9'd3);
    c = 0;
    while (bus.rd_req !== 1'b1 && c < 8) begin step(); c++; end
    n_checks++; if (bus.rd_req !== 1'b1) begin n_fail++; $display("FAIL midreset_req: rd_req=%b expected 1", bus.rd_req); end
    reset_n = 0; bus.req_valid = 0;
    step();
    wait_cnt = 0; bus.rd_ack = 0; reset_n = 1;
    n_checks++; if (bus.rd_req !== 1'b0 || bus.req_ack !== 1'b0 || bus.tag_busy !== 16'h0 || bus.outstanding_cnt !== 5'd0) begin
      n_fail++; $display("FAIL midreset_state: rd_req=%b ack=%b busy=%h cnt=%0d expected 0 0 0 0",
                         bus.rd_req, bus.req_ack, bus.tag_busy, bus.outstanding_cnt); end
    wait_grant(5, src, saw);
    n_checks++; if (src !== 0 || saw !== 1'b0) begin n_fail++; $display("FAIL midreset_quiet: src=%0d req=%b expected 0 0", src, saw); end
    ack_delay = 0;
    set_fresh(64'h1C00, 4'd4, 9'd0);
    wait_grant(10, src, saw);
    bus.req_valid = 0;
    n_checks++; if (src !== 1 || saw !== 1'b0 || bus.tag_busy !== 16'h0 || bus.outstanding_cnt !== 5'd0) begin
      n_fail++; $display("FAIL zero_len: src=%0d rd_req_seen=%b busy=%h cnt=%0d expected 1 0 0 0",
                         src, saw, bus.tag_busy, bus.outstanding_cnt); end
    step();
    n_checks++; if (bus.req_ack !== 1'b0) begin n_fail++; $display("FAIL zero_len_pulse: req_ack=%b expected 0", bus.req_ack); end
  endtask

  // Transaction-level model: one arbitration decision per idle window.
  task automatic test_random();
    bit mbusy[16]; int mcnt; int mstreak;
    bit fv, rv, felig, saw; int exp_src, src; int id;
    logic [63:0] fa, ra; logic [3:0] ft, rt; logic [8:0] fq; logic [9:0] rdw;
    logic [15:0] mvec;
    do_reset();
    foreach (mbusy[i]) mbusy[i] = 0;
    mcnt = 0; mstreak = 0; fv = 0; rv = 0;
    for (int r = 0; r < 120; r++) begin
      if (!fv && $urandom_range(0, 3) != 0) begin
        fv = 1; fa = {$urandom, $urandom}; ft = 4'($urandom_range(0, 15));
        fq = ($urandom_range(0, 7) == 0) ? 9'd0 : 9'($urandom_range(1, 511));
        set_fresh(fa, ft, fq);
      end
      if (!rv && $urandom_range(0, 2) == 0) begin
        rv = 1; ra = {$urandom, $urandom}; rt = 4'($urandom_range(0, 15)); rdw = 10'($urandom_range(0, 1023));
        bus.retry_valid = 1; bus.retry_addr = ra; bus.retry_tag = rt; bus.retry_dwords = rdw;
      end
      ack_delay = $urandom_range(0, 3);
      felig = fv && (mcnt < MAXO) && !mbusy[ft];
      if (rv && (!felig || mstreak < BURST)) exp_src = 2;
      else if (felig) exp_src = 1;
      else exp_src = 0;
      id = -1;
      if (exp_src == 0) begin
        if (fv) begin
          wait_grant(6, src, saw);
          n_checks++; if (src !== 0) begin n_fail++; $display("FAIL rand_stall[%0d]: got %0d expected 0", r, src); end
          if (mbusy[ft]) id = ft;
          else for (int k = 0; k < 16; k++) if (mbusy[k] && id < 0) id = k;
        end
      end else begin
        wait_grant(40, src, saw);
        n_checks++; if (src !== exp_src) begin n_fail++; $display("FAIL rand_src[%0d]: got %0d expected %0d", r, src, exp_src); end
        if (exp_src == 2) begin
          n_checks++; if (hs_seen !== 1'b1 || hs_addr !== ra || hs_tag !== rt || hs_dw !== rdw) begin
            n_fail++; $display("FAIL rand_retry[%0d]: addr=%h tag=%0d dw=%0d expected %h %0d %0d", r, hs_addr, hs_tag, hs_dw, ra, rt, rdw); end
          mstreak = felig ? ((mstreak < BURST) ? mstreak + 1 : mstreak) : 0;
          rv = 0; bus.retry_valid = 0;
        end else begin
          if (fq == 9'd0) begin
            n_checks++; if (saw !== 1'b0) begin n_fail++; $display("FAIL rand_zero[%0d]: rd_req seen, expected none", r); end
          end else begin
            n_checks++; if (hs_seen !== 1'b1 || hs_addr !== fa || hs_tag !== ft || hs_dw !== 10'(fq * 2)) begin
              n_fail++; $display("FAIL rand_fresh[%0d]: addr=%h tag=%0d dw=%0d expected %h %0d %0d", r, hs_addr, hs_tag, hs_dw, fa, ft, fq * 2); end
            mbusy[ft] = 1; mcnt++;
          end
          mstreak = 0; fv = 0; bus.req_valid = 0;
        end
        if ($urandom_range(0, 1) == 0) id = $urandom_range(0, 15);
      end
      if (id >= 0) begin
        bus.tag_release = 1; bus.tag_release_id = 4'(id);
        if (mbusy[id]) begin mbusy[id] = 0; mcnt--; end
      end
      step();
      for (int k = 0; k < 16; k++) mvec[k] = mbusy[k];
      n_checks++; if (bus.tag_busy !== mvec || bus.outstanding_cnt !== 5'(mcnt)) begin
        n_fail++; $display("FAIL rand_track[%0d]: busy=%h cnt=%0d expected %h %0d", r, bus.tag_busy, bus.outstanding_cnt, mvec, mcnt); end
    end
    bus.req_valid = 0; bus.retry_valid = 0;
    repeat (4) step();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fresh_only();
    test_retry_burst();
    test_outstanding_limit();
    test_tag_reuse();
    test_simul_release();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
